// File: rtl/dmem_axi_bridge.sv
// SRAM-like data-memory port to AXI master bridge with a single outstanding transaction.
// Loads use AR/R and stores use AW/W/B. The load data path from the R channel is combinational.
module dmem_axi_bridge (
  input  logic        clk,
  input  logic        rst,
  // SRAM-like side (MEM stage)
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_ok,
  output logic [31:0] data_rdata,
  // AXI read address / data
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address / data / response
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP
  } state_e;

  state_e      state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  axi_size;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // NOTE: the request fields are only consumed after being loaded on an accept,
  // so they carry no reset; only control state needs a known value.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    wdata_q <= wdata_d;
  end

  // NOTE: every signal assigned below gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    data_addr_ok = 1'b0;
    data_ok      = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        data_addr_ok = data_req;
        if (data_req) begin
          addr_d    = data_addr;
          size_d    = data_size;
          wdata_d   = data_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = data_wr ? S_WR_REQ : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          data_ok = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR_REQ: begin
        // AW and W complete independently; leave once both are done, even if in the same cycle.
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q | (awvalid & awready);
        w_done_d  = w_done_q | (wvalid & wready);
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          data_ok = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Size 3 has no AXI meaning here and is issued as a word access.
  assign axi_size = (size_q == 2'd3) ? 3'b010 : {1'b0, size_q};

  always_comb begin
    unique case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = 4'b0011 << {addr_q[1], 1'b0};
      default: wstrb = 4'b1111;
    endcase
  end

  assign araddr     = addr_q;
  assign awaddr     = addr_q;
  assign arsize     = axi_size;
  assign awsize     = axi_size;
  assign wdata      = wdata_q;
  assign data_rdata = rdata;

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Self-checking bench for dmem_axi_bridge: directed scenarios plus randomized
// transactions with a cycle-offset reference model of the expected handshakes.
module tb_dmem_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_ok;
  logic [31:0] data_rdata;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  int vectors    = 0;
  int miscompares = 0;

  dmem_axi_bridge dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_ok(data_ok), .data_rdata(data_rdata),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte lanes touched by an access of (1 << size) bytes placed at its natural lane.
  function automatic logic [3:0] ref_strb(input logic [1:0] size, input logic [31:0] addr);
    int nbytes, lane;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    lane   = (size == 2'd0) ? int'(addr % 4) : (size == 2'd1) ? int'(addr % 4) / 2 * 2 : 0;
    return 4'(((1 << nbytes) - 1) << lane);
  endfunction

  function automatic logic [2:0] ref_axsize(input logic [1:0] size);
    return (size == 2'd3) ? 3'd2 : 3'(size);
  endfunction

  task automatic slave_idle();
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_data_ok"}, 32'(data_ok), 32'd0);
    check({tag, "_arvalid"}, 32'(arvalid), 32'd0);
    check({tag, "_rready"},  32'(rready),  32'd0);
    check({tag, "_awvalid"}, 32'(awvalid), 32'd0);
    check({tag, "_wvalid"},  32'(wvalid),  32'd0);
    check({tag, "_bready"},  32'(bready),  32'd0);
  endtask

  // One full transaction, entered at posedge+1 with the DUT in IDLE. Cycle k counts from
  // the first cycle after the accept; the slave raises each ready/valid after its delay.
  task automatic run_txn(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int ar_d, input int aw_d, input int w_d,
                         input int r_d, input int b_d, input bit hold_req);
    int resp_k, done_k;
    data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    slave_idle();
    @(negedge clk);
    check("accept_addr_ok", 32'(data_addr_ok), 32'd1);
    check("accept_data_ok", 32'(data_ok), 32'd0);
    @(posedge clk); #1;
    resp_k = wr ? ((aw_d > w_d ? aw_d : w_d) + 1) : (ar_d + 1);
    done_k = resp_k + (wr ? b_d : r_d);
    for (int k = 0; k <= done_k; k++) begin
      // Scramble the request side to show the latched fields are held.
      data_req   = hold_req ? 1'b1 : 1'($urandom);
      data_wr    = 1'($urandom);
      data_size  = 2'($urandom);
      data_addr  = $urandom;
      data_wdata = $urandom;
      arready = (k >= ar_d);
      awready = (k >= aw_d);
      wready  = (k >= w_d);
      rvalid  = !wr && (k == done_k);
      bvalid  = wr && (k == done_k);
      rdata   = (k == done_k) ? rd : $urandom;
      @(negedge clk);
      check("busy_addr_ok", 32'(data_addr_ok), 32'd0);
      check("data_ok", 32'(data_ok), 32'(k == done_k));
      if (!wr) begin
        check("arvalid", 32'(arvalid), 32'(k <= ar_d));
        check("rready", 32'(rready), 32'(k >= resp_k));
        check("rd_awvalid", 32'(awvalid | wvalid | bready), 32'd0);
        if (k <= ar_d) begin
          check("araddr", araddr, addr);
          check("arsize", 32'(arsize), 32'(ref_axsize(size)));
        end
        if (k == done_k) check("data_rdata", data_rdata, rd);
      end else begin
        check("awvalid", 32'(awvalid), 32'(k <= aw_d));
        check("wvalid", 32'(wvalid), 32'(k <= w_d));
        check("bready", 32'(bready), 32'(k >= resp_k));
        check("wr_arvalid", 32'(arvalid | rready), 32'd0);
        if (k <= aw_d) begin
          check("awaddr", awaddr, addr);
          check("awsize", 32'(awsize), 32'(ref_axsize(size)));
        end
        if (k <= w_d) begin
          check("wdata", wdata, wd);
          check("wstrb", 32'(wstrb), 32'(ref_strb(size, addr)));
        end
      end
      @(posedge clk); #1;
    end
    slave_idle();
    data_req = hold_req;
  endtask

  initial begin
    rst = 1'b1;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
    slave_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_addr_ok", 32'(data_addr_ok), 32'd0);
    check_all_idle("reset");
    @(posedge clk); #1;

    // Load word, always-ready slave: accept, arvalid, data_ok on consecutive cycles.
    run_txn(1'b0, 2'd2, 32'h1FC0_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1'b0);
    // Byte store at lane 3.
    run_txn(1'b1, 2'd0, 32'h8000_0003, 32'hAB00_0000, 32'h0, 0, 0, 0, 0, 1, 1'b0);
    // Word store with slow AW, immediate W.
    run_txn(1'b1, 2'd2, 32'h0000_1000, 32'h1122_3344, 32'h0, 0, 3, 0, 0, 0, 1'b0);
    // Slow W, immediate AW, and both completing together.
    run_txn(1'b1, 2'd2, 32'h0000_2000, 32'h5566_7788, 32'h0, 0, 0, 2, 0, 2, 1'b0);
    run_txn(1'b1, 2'd2, 32'h0000_2004, 32'h99AA_BBCC, 32'h0, 0, 2, 2, 0, 0, 1'b0);
    // Half store at upper half, and size-3 load.
    run_txn(1'b1, 2'd1, 32'h0000_3002, 32'hBEEF_0000, 32'h0, 0, 0, 0, 0, 0, 1'b0);
    run_txn(1'b0, 2'd3, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 1, 0, 0, 2, 0, 1'b0);

    // Back-to-back loads with data_req held high.
    for (int n = 0; n < 3; n++)
      run_txn(1'b0, 2'd2, 32'h0000_5000 + 32'(n * 4), 32'h0, 32'h0A0B_0C00 + 32'(n), 0, 0, 0, 0, 0, 1'b1);

    // Reset while in RD_DATA, then a stray rvalid.
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0100;
    @(negedge clk);
    check("rst_rd_accept", 32'(data_addr_ok), 32'd1);
    @(posedge clk); #1;
    data_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    check("rst_rd_arvalid", 32'(arvalid), 32'd1);
    @(posedge clk); #1;
    arready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_rd_rready", 32'(rready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    data_req = 1'b1; data_addr = 32'h0000_0200;
    @(negedge clk);
    check("post_rst_addr_ok", 32'(data_addr_ok), 32'd1);
    check_all_idle("post_rst");
    @(posedge clk); #1;
    rvalid = 1'b0; data_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    check("post_rst_arvalid", 32'(arvalid), 32'd1);
    check("post_rst_araddr", araddr, 32'h0000_0200);
    @(posedge clk); #1;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
    @(negedge clk);
    check("post_rst_data_ok", 32'(data_ok), 32'd1);
    check("post_rst_rdata", data_rdata, 32'h1234_5678);
    @(posedge clk); #1;
    slave_idle();

    // Reset in WR_REQ after W has completed; the W-done flag must not survive.
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h0000_0300;
    @(negedge clk);
    check("rst_wr_accept", 32'(data_addr_ok), 32'd1);
    @(posedge clk); #1;
    data_req = 1'b0; wready = 1'b1;
    @(negedge clk);
    check("rst_wr_wvalid", 32'(wvalid), 32'd1);
    @(posedge clk); #1;
    wready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_wr_wvalid_drop", 32'(wvalid), 32'd0);
    check("rst_wr_awvalid_hold", 32'(awvalid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_idle("rst_wr");
    @(posedge clk); #1;
    run_txn(1'b1, 2'd2, 32'h0000_0400, 32'h0F0F_0F0F, 32'h0, 0, 0, 2, 0, 0, 1'b0);

    // Randomized transactions.
    for (int n = 0; n < 40; n++)
      run_txn(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
